// File: rtl/key_expansion_if.sv
// Key-schedule bus: start/key request in, busy/done status and the round-key array out.
interface key_expansion_if #(
  parameter int Nk = 4,
  parameter int Nr = 10
);
  logic                      start;
  logic [0:32*Nk-1]          key;
  logic                      busy;
  logic                      done;
  logic [32*(4*Nr+4)-1:0]    w;

  modport master (output start, key, input busy, done, w);
  modport slave  (input start, key, output busy, done, w);
endinterface

// File: rtl/key_expansion.sv
// AES key schedule: one round-key word per clock through a single shared SubWord unit.
//   state   | meaning
//   ST_IDLE | waiting for start; w holds the last completed (or reset) schedule
//   ST_RUN  | writing word idx from w[idx-1] and w[idx-Nk]; busy is high
module key_expansion #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  key_expansion_if.slave bus
);

  localparam int NW = 4 * Nr + 4;
  localparam int IW = $clog2(NW);

  if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14))) begin : g_bad_params
    $error("key_expansion: illegal Nk/Nr pairing");
  end

  // Entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t          state;
  logic [31:0]     wr [NW];
  logic [IW-1:0]   idx;
  logic [3:0]      cnt;
  logic [7:0]      rcon;
  logic            done_q;

  logic [IW-1:0]   prev_i, back_i;
  logic [31:0]     prev, back, sub_in, sub_out, temp, nxt;

  always_comb begin
    prev_i = idx - IW'(1);
    back_i = idx - IW'(Nk);
    if (state != ST_RUN) begin
      prev_i = '0;
      back_i = '0;
    end
    prev    = wr[prev_i];
    back    = wr[back_i];
    sub_in  = (cnt == 4'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out = {sb(sub_in[31:24]), sb(sub_in[23:16]), sb(sub_in[15:8]), sb(sub_in[7:0])};
    if (cnt == 4'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (Nk == 8 && cnt == 4'd4)
      temp = sub_out;
    else
      temp = prev;
    nxt = back ^ temp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      for (int k = 0; k < NW; k++) wr[k] <= '0;
      idx    <= '0;
      cnt    <= '0;
      rcon   <= 8'h01;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            for (int k = 0; k < Nk; k++) wr[k] <= bus.key[32*k +: 32];
            idx   <= IW'(Nk);
            cnt   <= '0;
            rcon  <= 8'h01;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          wr[idx] <= nxt;
          if (cnt == 4'd0) rcon <= rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b) : {rcon[6:0], 1'b0};
          cnt <= (cnt == 4'(Nk - 1)) ? 4'd0 : cnt + 4'd1;
          if (idx == IW'(NW - 1)) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.done = done_q;

  for (genvar k = 0; k < NW; k++) begin : g_w
    assign bus.w[32*k +: 32] = wr[k];
  end

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: AES-128/192/256 instances against known-answer words and a GF(2^8) reference model.
module tb_key_expansion;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_expansion_if #(.Nk(4), .Nr(10)) if4 ();
  key_expansion_if #(.Nk(6), .Nr(12)) if6 ();
  key_expansion_if #(.Nk(8), .Nr(14)) if8 ();

  key_expansion #(.Nk(4), .Nr(10)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  key_expansion #(.Nk(6), .Nr(12)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6));
  key_expansion #(.Nk(8), .Nr(14)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  logic           start_a [3];
  logic [0:255]   key_a   [3];
  logic           busy_a  [3];
  logic           done_a  [3];
  logic [1919:0]  w_a     [3];

  assign if4.start = start_a[0];
  assign if6.start = start_a[1];
  assign if8.start = start_a[2];
  assign if4.key   = key_a[0][0:127];
  assign if6.key   = key_a[1][0:191];
  assign if8.key   = key_a[2];
  assign busy_a[0] = if4.busy;
  assign busy_a[1] = if6.busy;
  assign busy_a[2] = if8.busy;
  assign done_a[0] = if4.done;
  assign done_a[1] = if6.done;
  assign done_a[2] = if8.done;
  assign w_a[0]    = {512'h0, if4.w};
  assign w_a[1]    = {256'h0, if6.w};
  assign w_a[2]    = if8.w;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference S-box derived from GF(2^8) inversion plus the affine map.
  logic [7:0] sbx [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbx[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbx[t[31:24]], sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]};
  endfunction

  function automatic logic [1919:0] model(input int nk, input logic [0:255] key);
    logic [31:0]   wm [60];
    logic [7:0]    rc [10];
    logic [31:0]   t;
    logic [1919:0] res;
    int            nw;
    rc  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    nw  = 4 * (nk + 6) + 4;
    res = '0;
    for (int i = 0; i < nk; i++) wm[i] = key[32*i +: 32];
    for (int i = nk; i < nw; i++) begin
      t = wm[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk-1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      wm[i] = wm[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) res[32*i +: 32] = wm[i];
    return res;
  endfunction

  typedef struct {
    int            inst;
    logic [1919:0] w;
  } exp_t;
  exp_t sb_q[$];

  task automatic cmp_w(input int inst, input string nm);
    exp_t e;
    int   first;
    if (sb_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
      return;
    end
    e = sb_q.pop_front();
    total++;
    if (w_a[inst] !== e.w) begin
      bad++;
      first = -1;
      for (int k = 59; k >= 0; k--)
        if (w_a[inst][32*k +: 32] !== e.w[32*k +: 32]) first = k;
      $display("FAIL %s inst%0d: word %0d got %h want %h", nm, inst, first,
               w_a[inst][32*first +: 32], e.w[32*first +: 32]);
    end
  endtask

  // Drive start at posedge+1, return at posedge+1 of the done cycle (or after the budget).
  task automatic run(input int inst, input logic [0:255] key, input string nm);
    int n, lat;
    bit seen;
    lat = (inst == 0) ? 40 : (inst == 1) ? 46 : 52;
    key_a[inst]   = key;
    start_a[inst] = 1'b1;
    sb_q.push_back('{inst, model(4 + 2*inst, key)});
    @(posedge clk); #1;
    start_a[inst] = 1'b0;
    key_a[inst]   = ~key;
    chk({nm, "_busy_after_start"}, 64'(busy_a[inst]), 64'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done_a[inst]) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    if (!seen) begin
      void'(sb_q.pop_front());
      return;
    end
    chk({nm, "_latency"}, 64'(n), 64'(lat));
    chk({nm, "_busy_at_done"}, 64'(busy_a[inst]), 64'd0);
    cmp_w(inst, nm);
  endtask

  task automatic after_done(input int inst, input string nm);
    logic [1919:0] held;
    held = w_a[inst];
    @(posedge clk); #1;
    chk({nm, "_done_one_cycle"}, 64'(done_a[inst]), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_w_held"}, 64'(w_a[inst] === held), 64'd1);
  endtask

  typedef struct {
    int           inst;
    logic [0:255] key;
    int           widx;
    logic [31:0]  exp;
  } vec_t;

  localparam logic [0:255] K128A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:255] K128B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [0:255] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  vec_t vt [18];

  initial begin
    int           last_inst;
    logic [0:255] last_key;
    int           n;
    bit           seen;

    vt[0]  = '{0, K128A,  0, 32'h00010203};
    vt[1]  = '{0, K128A,  3, 32'h0c0d0e0f};
    vt[2]  = '{0, K128A,  4, 32'hd6aa74fd};
    vt[3]  = '{0, K128A,  5, 32'hd2af72fa};
    vt[4]  = '{0, K128A,  6, 32'hdaa678f1};
    vt[5]  = '{0, K128A,  7, 32'hd6ab76fe};
    vt[6]  = '{0, K128A, 40, 32'h13111d7f};
    vt[7]  = '{0, K128A, 41, 32'he3944a17};
    vt[8]  = '{0, K128A, 42, 32'hf307a78b};
    vt[9]  = '{0, K128A, 43, 32'h4d2b30c5};
    vt[10] = '{0, K128B,  4, 32'ha0fafe17};
    vt[11] = '{0, K128B, 43, 32'hb6630ca6};
    vt[12] = '{1, K192,   6, 32'h5846f2f9};
    vt[13] = '{1, K192,   7, 32'h5c43f4fe};
    vt[14] = '{2, K256,   8, 32'ha573c29f};
    vt[15] = '{2, K256,   9, 32'ha176c498};
    vt[16] = '{2, K256,  10, 32'ha97fce93};
    vt[17] = '{2, K256,  11, 32'ha572c09c};

    init_sbox();
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0;
      key_a[k]   = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_w%0d", k), 64'(w_a[k] === '0), 64'd1);
      chk($sformatf("reset_busy%0d", k), 64'(busy_a[k]), 64'd0);
      chk($sformatf("reset_done%0d", k), 64'(done_a[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    last_inst = -1;
    last_key  = '0;
    for (int i = 0; i < 18; i++) begin
      if (vt[i].inst != last_inst || vt[i].key !== last_key) begin
        run(vt[i].inst, vt[i].key, $sformatf("vec%0d_run", i));
        after_done(vt[i].inst, $sformatf("vec%0d", i));
        last_inst = vt[i].inst;
        last_key  = vt[i].key;
      end
      chk($sformatf("vec%0d_w%0d", i, vt[i].widx), 64'(w_a[vt[i].inst][32*vt[i].widx +: 32]),
          64'(vt[i].exp));
    end

    // Start and key changes while busy must be ignored.
    key_a[2]   = K256;
    start_a[2] = 1'b1;
    sb_q.push_back('{2, model(8, K256)});
    @(posedge clk); #1;
    key_a[2] = K128B;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 30) start_a[2] = 1'b0;
      if (done_a[2]) seen = 1'b1;
    end
    chk("ignore_done_seen", 64'(seen), 64'd1);
    chk("ignore_latency", 64'(n), 64'd52);
    if (seen) cmp_w(2, "ignore_w");
    else void'(sb_q.pop_front());
    after_done(2, "ignore");

    // Start in the done cycle is accepted.
    run(1, K192, "b2b_first");
    run(1, {192'hfedcba9876543210_0f1e2d3c4b5a6978_1122334455667788, 64'h0}, "b2b_second");
    after_done(1, "b2b");

    // Reset mid-expansion aborts without done.
    key_a[0]   = K128B;
    start_a[0] = 1'b1;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_w_zero", 64'(w_a[0] === '0), 64'd1);
    chk("abort_busy", 64'(busy_a[0]), 64'd0);
    chk("abort_done", 64'(done_a[0]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done_a[0] || busy_a[0]) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    run(0, {128'h3243f6a8885a308d313198a2e0370734, 128'h0}, "after_abort");
    after_done(0, "after_abort");
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_expansion.md
# key_expansion

AES key schedule (FIPS-197 KeyExpansion) for 128-, 192- and 256-bit keys, selected by parameter. It takes a cipher key and produces the full round-key array `w` of 4·(Nr+1) 32-bit words. It computes one word per clock with a single shared S-box. It sits in front of the cipher/inverse-cipher round datapath, which reads `w` after `done`.

## Interface
- `Nk`, 4: key length in 32-bit words. Legal values are 4, 6 and 8.
- `Nr`, 10: number of rounds. Legal values are 10, 12 and 14, paired with Nk = 4, 6, 8. Any other pairing is illegal, and elaboration must fail.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  request expansion of `key`. Sampled on a rising edge.
- `key`  in  [0:32·Nk-1]  cipher key, big-endian. Bits [0:31] are key word 0, with byte 0 in bits [0:7].
- `busy`  out  1  expansion in progress.
- `done`  out  1  one-cycle pulse: `w` is complete.
- `w`  out  [32·(4Nr+4)-1:0]  round-key words. Word k is `w[32k +: 32]`, and round r key word j is `w[128r + 32j +: 32]`. Each word has its first byte in its MSBs.

## Operation
- Accept `start` only when `busy`=0. Ignore `start` while `busy`=1.
- On an accepted start:
  - latch key words 0..Nk-1 into `w` words 0..Nk-1;
  - set index i = Nk, set Rcon register = 0x01, set `busy`=1.
  - All other `w` words keep their old values until overwritten.
- `key` is only sampled on the start edge and may change afterwards.
- On each busy cycle, compute word i from temp = w[i-1]:
  - if i mod Nk == 0: temp = SubWord(RotWord(temp)) XOR {Rcon, 00, 00, 00}, then Rcon = xtime(Rcon);
  - else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp);
  - w[i] = w[i-Nk] XOR temp; then i = i+1.
- RotWord: {a0,a1,a2,a3} → {a1,a2,a3,a0}. SubWord applies the AES S-box to each byte.
- xtime: shift left by 1; if the old bit 7 was set, XOR with 0x1B. The Rcon sequence is 01,02,04,08,10,20,40,80,1B,36.
- When the final word i = 4Nr+3 is written: clear `busy`, pulse `done` for one cycle, and hold `w` stable until the next accepted start.
- Index-modulo tests are done with a wrap counter (0..Nk-1), not a divider.
- The S-box is a 256-entry combinational lookup inside the block.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - `w` = 0, `busy` = 0, `done` = 0, i = 0, Rcon = 0x01.
  - Reset in mid-expansion aborts it; no `done` follows.
- Start edge E0 loads the key. Edges E1..E(4Nr+4-Nk) each write one word.
- `busy` is high from after E0 through the cycle ending at edge E(4Nr+4-Nk).
- `done`=1 for exactly the one cycle after E(4Nr+4-Nk).
- Latency from the start edge to `done` is 40 edges for AES-128, 46 for AES-192 and 52 for AES-256.
- A start asserted in the same cycle as `done` is accepted, because `busy`=0 in that cycle.
- Words are written in index order. Word k is valid from edge E(k-Nk+1) onward; the consumer uses `done` only.

## Test plan
- Nk=4, key 000102030405060708090a0b0c0d0e0f, one-cycle start → after 40 edges, `done` pulses once:
  - round 0 = 00010203 04050607 08090a0b 0c0d0e0f;
  - round 1 = d6aa74fd d2af72fa daa678f1 d6ab76fe;
  - round 10 = 13111d7f e3944a17 f307a78b 4d2b30c5.
- Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c → w4 = a0fafe17, w43 = b6630ca6.
- Nk=6/Nr=12, key 000102…1617 → w6 = 5846f2f9, w7 = 5c43f4fe, `done` after 46 edges.
- Nk=8/Nr=14, key 000102…1e1f → round 2 = a573c29f a176c498 a97fce93 a572c09c, `done` after 52 edges. This checks the SubWord-only step at i mod 8 == 4.
- Assert start again, and change `key`, while busy → both ignored; the result equals the first key's expansion.
- Pull `rst_n` low at edge 20 of an expansion → `w`=0, `busy`=0, no `done`. A fresh start after release gives the correct result.
